branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch-resolution controller for the EX stage of the five-stage RISC-V core. It accepts one control-transfer instruction at a time from ID/EX and waits for forwarded operands. It sequences the external combinational branch comparator (`in_a`/`in_b`/`unsign` → `br_eq`/`br_lt`), decides taken/not-taken, computes the target, and drives the PC redirect plus a multi-cycle front-end flush. It also maintains saturating branch/taken performance counters.

## Interface
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a taken redirect (legal range 1–7).
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `br_valid` in 1: ID/EX presents a control-transfer instruction.
- `br_ready` out 1: controller can accept; transfer when `br_valid & br_ready`.
- `br_kind` in 2: 00 conditional branch, 01 JAL, 10 JALR, 11 reserved (treated as not-taken, no illegal flag).
- `br_funct3` in 3: branch condition.
- `br_pc` in 32: instruction PC.
- `br_imm` in 32: sign-extended immediate.
- `rs1_data` in 32: forwarded rs1.
- `rs2_data` in 32: forwarded rs2.
- `ops_ok` in 1: rs1/rs2 values are valid this cycle.
- `kill` in 1: synchronous abort from a later-stage trap.
- `cnt_clear` in 1: synchronous clear of both counters.
- `cmp_a` out 32: to comparator `in_a`.
- `cmp_b` out 32: to comparator `in_b`.
- `cmp_unsign` out 1: to comparator `unsign`.
- `cmp_eq` in 1: comparator `br_eq`.
- `cmp_lt` in 1: comparator `br_lt`.
- `redirect_valid` out 1: one-cycle PC redirect strobe.
- `redirect_pc` out 32: redirect target; valid with `redirect_valid`.
- `flush` out 1: squash IF/ID and ID/EX.
- `done` out 1: one-cycle pulse when an instruction is resolved.
- `illegal` out 1: one-cycle pulse when a conditional branch has funct3 010/011.
- `misaligned` out 1: one-cycle pulse when a taken target has bit 1 set.
- `cnt_branches` out 32: conditional branches resolved (saturating).
- `cnt_taken` out 32: conditional branches taken (saturating).

## Operation
- States: IDLE, WAIT_OPS, RESOLVE, FLUSH. `br_ready` = (state == IDLE).
- IDLE:
  - On handshake, latch kind, funct3, pc, imm.
  - If `ops_ok`, latch rs1/rs2 and go to RESOLVE; otherwise go to WAIT_OPS.
- WAIT_OPS: on `ops_ok`, latch rs1/rs2 and go to RESOLVE.
- `cmp_a`/`cmp_b` always drive the latched rs1/rs2. `cmp_unsign` = latched `funct3[1]`.
- RESOLVE, taken condition by funct3:
  - 000 `eq`; 001 `!eq`; 100 `lt`; 101 `!lt`; 110 `lt`; 111 `!lt`.
  - 010/011: not-taken and `illegal` pulse.
  - JAL and JALR are always taken; comparator result is ignored.
- Target:
  - Branch/JAL: `pc + imm`, modulo 2^32.
  - JALR: `(rs1 + imm) & ~1`.
- Taken target with bit 1 = 1: no redirect, no flush, `misaligned` pulse, return to IDLE.
- Taken and aligned: go to FLUSH, load the flush counter with FLUSH_CYCLES. Otherwise go to IDLE.
- FLUSH: `flush`=1 and the counter decrements each cycle. Go to IDLE after the cycle in which the counter reaches 1.
- Counters update at RESOLVE for `br_kind`=00 only:
  - `cnt_branches` +1; `cnt_taken` +1 if taken and aligned.
  - Both hold at 0xFFFFFFFF.
  - `cnt_clear` zeroes both and wins over a same-cycle increment.
- `kill` (highest priority, any state): next state IDLE. It suppresses that cycle's redirect, flush, done, illegal, misaligned and counter updates. Latched operands are don't-care.

## Timing
- Reset values:
  - state IDLE; `br_ready` 1.
  - `redirect_valid`, `flush`, `done`, `illegal`, `misaligned` all 0.
  - `redirect_pc`, `cmp_a`, `cmp_b` 0; `cmp_unsign` 0; counters 0.
- All outputs except `br_ready`, `cmp_*` are registered.
- Handshake in cycle N with `ops_ok`=1: RESOLVE in N+1. In N+2, `done`=1 (and `illegal`/`misaligned` as applicable).
  - If taken: `redirect_valid`=1 and `flush`=1 in N+2; `flush` stays high through N+1+FLUSH_CYCLES; `br_ready`=1 in N+2+FLUSH_CYCLES.
  - If not taken: `br_ready`=1 in N+2.
- Each cycle of `ops_ok`=0 adds one cycle before RESOLVE.
- `kill` asserted in the RESOLVE cycle: no pulses in the next cycle.
- `kill` asserted in a FLUSH cycle: `flush` drops the next cycle.
- `reset_n` low mid-operation: immediate return to reset values.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20 → N+2: `redirect_valid`=1, `redirect_pc`=0x120; `flush` high 2 cycles; `cnt_taken`=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. Same operands with BLTU (`cmp_unsign`=1) → not taken, `done` only, `br_ready` back at N+2.
- `ops_ok` low 3 cycles after handshake → RESOLVE delayed 3 cycles; `cmp_a` equals the value captured on the `ops_ok` cycle.
- JALR rs1=0x1001, imm=0x4 → `redirect_pc`=0x1004. JAL pc=0x100, imm=0x2 → `misaligned`=1, no redirect.
- funct3=010 → `illegal`=1, not taken. `kill` in the first FLUSH cycle → `flush` low next cycle, `br_ready`=1.
- Force `cnt_branches`=0xFFFFFFFF and resolve a branch → stays 0xFFFFFFFF. `cnt_clear` same cycle as an increment → 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: sequences the external comparator, decides taken/not-taken,
// drives the PC redirect and a multi-cycle front-end flush, and keeps saturating branch counters.
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [1:0]  br_kind,
  input  logic [2:0]  br_funct3,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        ops_ok,
  input  logic        kill,
  input  logic        cnt_clear,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  output logic        cmp_unsign,
  input  logic        cmp_eq,
  input  logic        cmp_lt,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        done,
  output logic        illegal,
  output logic        misaligned,
  output logic [31:0] cnt_branches,
  output logic [31:0] cnt_taken
);

  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE, FLUSH} state_e;

  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d, done_q, done_d;
  logic        illegal_q, illegal_d, misaligned_q, misaligned_d;
  logic [31:0] cnt_branches_q, cnt_branches_d, cnt_taken_q, cnt_taken_d;

  logic        taken, cond_ill, redirect_ok;
  logic [31:0] target;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign br_ready   = (state_q == IDLE);
  assign cmp_a      = rs1_q;
  assign cmp_b      = rs2_q;
  assign cmp_unsign = funct3_q[1];

  // Resolution from the latched instruction and the comparator answer
  always_comb begin
    taken    = 1'b0;
    cond_ill = 1'b0;
    unique case (kind_q)
      KIND_BR: begin
        unique case (funct3_q)
          3'b000:         taken = cmp_eq;
          3'b001:         taken = !cmp_eq;
          3'b100, 3'b110: taken = cmp_lt;
          3'b101, 3'b111: taken = !cmp_lt;
          default:        cond_ill = 1'b1;
        endcase
      end
      KIND_JAL, KIND_JALR: taken = 1'b1;
      default:             taken = 1'b0;
    endcase
    if (kind_q == KIND_JALR) target = (rs1_q + imm_q) & 32'hFFFF_FFFE;
    else                     target = pc_q + imm_q;
    redirect_ok = taken & ~target[1];
  end

  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    funct3_d         = funct3_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    fcnt_d           = fcnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    done_d           = 1'b0;
    illegal_d        = 1'b0;
    misaligned_d     = 1'b0;
    cnt_branches_d   = cnt_branches_q;
    cnt_taken_d      = cnt_taken_q;

    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (br_valid) begin
            kind_d   = br_kind;
            funct3_d = br_funct3;
            pc_d     = br_pc;
            imm_d    = br_imm;
            if (ops_ok) begin
              rs1_d   = rs1_data;
              rs2_d   = rs2_data;
              state_d = RESOLVE;
            end else begin
              state_d = WAIT_OPS;
            end
          end
        end
        WAIT_OPS: begin
          if (ops_ok) begin
            rs1_d   = rs1_data;
            rs2_d   = rs2_data;
            state_d = RESOLVE;
          end
        end
        RESOLVE: begin
          done_d       = 1'b1;
          illegal_d    = cond_ill;
          misaligned_d = taken & target[1];
          if (redirect_ok) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            flush_d          = 1'b1;
            fcnt_d           = FLUSH_INIT;
            state_d          = FLUSH;
          end else begin
            state_d = IDLE;
          end
          if (kind_q == KIND_BR) begin
            cnt_branches_d = sat_inc(cnt_branches_q);
            if (redirect_ok) cnt_taken_d = sat_inc(cnt_taken_q);
          end
        end
        FLUSH: begin
          fcnt_d = fcnt_q - 3'd1;
          // flush is registered, so it stays up only while more flush cycles remain
          if (fcnt_q <= 3'd1) state_d = IDLE;
          else                flush_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (cnt_clear) begin
      cnt_branches_d = '0;
      cnt_taken_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      kind_q           <= '0;
      funct3_q         <= '0;
      pc_q             <= '0;
      imm_q            <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      fcnt_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      done_q           <= 1'b0;
      illegal_q        <= 1'b0;
      misaligned_q     <= 1'b0;
      cnt_branches_q   <= '0;
      cnt_taken_q      <= '0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      funct3_q         <= funct3_d;
      pc_q             <= pc_d;
      imm_q            <= imm_d;
      rs1_q            <= rs1_d;
      rs2_q            <= rs2_d;
      fcnt_q           <= fcnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      done_q           <= done_d;
      illegal_q        <= illegal_d;
      misaligned_q     <= misaligned_d;
      cnt_branches_q   <= cnt_branches_d;
      cnt_taken_q      <= cnt_taken_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign done           = done_q;
  assign illegal        = illegal_q;
  assign misaligned     = misaligned_q;
  assign cnt_branches   = cnt_branches_q;
  assign cnt_taken      = cnt_taken_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: expected resolutions are queued at issue and
// compared when done pulses; timing, kill, counters and reset are checked inline.
module tb_branch_ctrl;

  localparam int FC = 2;

  logic        clock, reset_n;
  logic        br_valid, br_ready;
  logic [1:0]  br_kind;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc, br_imm, rs1_data, rs2_data;
  logic        ops_ok, kill, cnt_clear;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_unsign, cmp_eq, cmp_lt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush, done, illegal, misaligned;
  logic [31:0] cnt_branches, cnt_taken;

  branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset_n(reset_n),
    .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind), .br_funct3(br_funct3),
    .br_pc(br_pc), .br_imm(br_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ops_ok(ops_ok), .kill(kill), .cnt_clear(cnt_clear),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_unsign(cmp_unsign), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .done(done),
    .illegal(illegal), .misaligned(misaligned),
    .cnt_branches(cnt_branches), .cnt_taken(cnt_taken)
  );

  // external comparator
  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_lt = cmp_unsign ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

  typedef struct packed {
    logic        rv;
    logic        ill;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        me;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_tk = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic exp_t model(input logic [1:0] k, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic        tk;
    logic [31:0] tgt;
    e  = '0;
    tk = 1'b0;
    if (k == 2'b00) begin
      case (f3)
        3'b000:  tk = (r1 == r2);
        3'b001:  tk = (r1 != r2);
        3'b100:  tk = ($signed(r1) < $signed(r2));
        3'b101:  tk = ($signed(r1) >= $signed(r2));
        3'b110:  tk = (r1 < r2);
        3'b111:  tk = (r1 >= r2);
        default: e.ill = 1'b1;
      endcase
    end else if (k == 2'b01 || k == 2'b10) begin
      tk = 1'b1;
    end
    tgt   = (k == 2'b10) ? ((r1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.mis = tk & tgt[1];
    e.rv  = tk & ~tgt[1];
    e.pc  = tgt;
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", done, 1'b0);
      end else begin
        me = sb_q.pop_front();
        chk("sb_redirect_valid", redirect_valid, me.rv);
        if (me.rv) chk("sb_redirect_pc", redirect_pc, me.pc);
        chk("sb_illegal", illegal, me.ill);
        chk("sb_misaligned", misaligned, me.mis);
        chk("sb_flush", flush, me.rv);
      end
    end
  end

  // mode: 0 normal, 1 kill in RESOLVE, 2 kill in first FLUSH, 3 cnt_clear in RESOLVE, 4 reset in FLUSH
  task automatic send(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                      input int ow, input int mode);
    exp_t e;
    int   n;
    int   hs;
    e = model(k, f3, pc, imm, r1, r2);
    if (mode != 1) sb_q.push_back(e);
    if (mode == 3) begin
      exp_br = 0;
      exp_tk = 0;
    end else if (mode != 1 && k == 2'b00) begin
      exp_br = sat(exp_br);
      if (e.rv) exp_tk = sat(exp_tk);
    end

    @(negedge clock);
    chk("ready_idle", br_ready, 1'b1);
    br_valid  = 1'b1;
    br_kind   = k;
    br_funct3 = f3;
    br_pc     = pc;
    br_imm    = imm;
    ops_ok    = (ow == 0);
    rs1_data  = (ow == 0) ? r1 : $urandom();
    rs2_data  = (ow == 0) ? r2 : $urandom();
    @(posedge clock); #1;
    hs        = cyc;
    br_valid  = 1'b0;
    br_kind   = 2'($urandom());
    br_funct3 = 3'($urandom());
    br_pc     = $urandom();
    br_imm    = $urandom();
    for (int i = 0; i < ow; i++) begin
      ops_ok   = (i == ow - 1);
      rs1_data = ops_ok ? r1 : $urandom();
      rs2_data = ops_ok ? r2 : $urandom();
      @(posedge clock); #1;
    end
    ops_ok   = 1'b0;
    rs1_data = $urandom();
    rs2_data = $urandom();
    if (mode == 1) kill = 1'b1;
    if (mode == 3) cnt_clear = 1'b1;
    @(posedge clock); #1;
    kill      = 1'b0;
    cnt_clear = 1'b0;
    @(negedge clock);

    if (mode == 1) begin
      chk("kill_done", done, 1'b0);
      chk("kill_redirect", redirect_valid, 1'b0);
      chk("kill_flush", flush, 1'b0);
      chk("kill_illegal", illegal, 1'b0);
      chk("kill_ready", br_ready, 1'b1);
      chk("kill_cnt_branches", cnt_branches, exp_br);
      return;
    end

    n = 0;
    while (!done && n < 12) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      chk("done_timeout", done, 1'b1);
      return;
    end
    chk("latency", cyc - hs, 1 + ow);
    chk("cmp_a", cmp_a, r1);
    chk("cmp_b", cmp_b, r2);
    chk("cmp_unsign", cmp_unsign, f3[1]);
    chk("cnt_branches", cnt_branches, exp_br);
    chk("cnt_taken", cnt_taken, exp_tk);

    if (e.rv) begin
      chk("ready_in_flush", br_ready, 1'b0);
      if (mode == 2) begin
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        chk("kill_flush_drop", flush, 1'b0);
        chk("kill_flush_ready", br_ready, 1'b1);
      end else if (mode == 4) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_flush", flush, 1'b0);
        chk("rst_mid_redirect", redirect_valid, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_ready", br_ready, 1'b1);
        chk("rst_mid_rpc", redirect_pc, 32'h0);
        chk("rst_mid_cmp_a", cmp_a, 32'h0);
        chk("rst_mid_cnt", cnt_branches, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_br  = 0;
        exp_tk  = 0;
      end else begin
        for (int i = 1; i < FC; i++) begin
          @(negedge clock);
          chk("flush_hold", flush, 1'b1);
          chk("redirect_one_shot", redirect_valid, 1'b0);
          chk("ready_low", br_ready, 1'b0);
        end
        @(negedge clock);
        chk("flush_end", flush, 1'b0);
        chk("ready_back", br_ready, 1'b1);
      end
    end else begin
      chk("ready_not_taken", br_ready, 1'b1);
      chk("flush_not_taken", flush, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3s [6];
    logic [31:0] a, b;
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    clock = 0; reset_n = 0; br_valid = 0; br_kind = 0; br_funct3 = 0;
    br_pc = 0; br_imm = 0; rs1_data = 0; rs2_data = 0; ops_ok = 0; kill = 0; cnt_clear = 0;
    #12;
    chk("rst_ready", br_ready, 1'b1);
    chk("rst_redirect_valid", redirect_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_misaligned", misaligned, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_cmp_a", cmp_a, 32'h0);
    chk("rst_cmp_b", cmp_b, 32'h0);
    chk("rst_cmp_unsign", cmp_unsign, 1'b0);
    chk("rst_cnt_branches", cnt_branches, 32'h0);
    chk("rst_cnt_taken", cnt_taken, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    send(2'b00, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5, 0, 0);                // BEQ taken
    send(2'b00, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 0);        // BLT taken
    send(2'b00, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 0, 0);        // BLTU not taken
    send(2'b00, 3'b001, 32'h400, 32'h10, 32'h11, 32'h22, 3, 0);              // BNE, late operands
    send(2'b10, 3'b000, 32'h800, 32'h4, 32'h1001, 32'h0, 0, 0);              // JALR
    send(2'b01, 3'b000, 32'h100, 32'h2, 32'h0, 32'h0, 0, 0);                 // JAL misaligned
    send(2'b00, 3'b010, 32'h100, 32'h8, 32'h3, 32'h3, 0, 0);                 // illegal funct3
    send(2'b00, 3'b101, 32'h300, 32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFFF, 0, 0); // BGE taken
    send(2'b00, 3'b111, 32'h300, 32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFFF, 1, 0); // BGEU not taken
    send(2'b11, 3'b000, 32'h300, 32'h10, 32'h7, 32'h7, 0, 0);                // reserved kind
    send(2'b00, 3'b000, 32'h500, 32'h8, 32'h7, 32'h7, 0, 1);                 // kill in RESOLVE
    send(2'b00, 3'b000, 32'h500, 32'h8, 32'h7, 32'h7, 0, 2);                 // kill in FLUSH

    for (int j = 0; j < 6; j++) begin
      a = $urandom();
      b = (j % 2 == 1) ? a : $urandom();
      send(2'b00, f3s[$urandom_range(0, 5)], 32'h1000 + 32'(j * 64),
           32'($urandom_range(0, 255)) << 2, a, b, $urandom_range(0, 2), 0);
    end

    @(negedge clock);
    force dut.cnt_branches_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_branches_q;
    exp_br = 32'hFFFF_FFFF;
    chk("sat_preload", cnt_branches, 32'hFFFF_FFFF);
    send(2'b00, 3'b000, 32'h600, 32'h4, 32'h1, 32'h2, 0, 0);                 // saturate
    send(2'b00, 3'b000, 32'h600, 32'h4, 32'h3, 32'h3, 0, 3);                 // clear beats increment
    send(2'b00, 3'b000, 32'h700, 32'h8, 32'h9, 32'h9, 0, 4);                 // reset in FLUSH
    send(2'b00, 3'b001, 32'h700, 32'hC, 32'h1, 32'h2, 0, 0);                 // after reset

    repeat (2) @(negedge clock);
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
